// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// MEM_ARB_RR_EN: contention goes to the requester not granted last;
// otherwise the load/store side always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       flush,
  input  arb_owner_e last_grant,
  output arb_owner_e winner
);

  logic if_ok;

  assign if_ok = if_req & ~flush;

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whoever did not have it last time
  always_comb begin
    winner = OWN_NONE;
    if (if_ok && dm_req) begin
      winner = (last_grant == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (dm_req) begin
      winner = OWN_DM;
    end else if (if_ok) begin
      winner = OWN_IF;
    end
  end
`else
  // Fixed priority: data traffic always beats fetch
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner = OWN_NONE;
    if (dm_req) begin
      winner = OWN_DM;
    end else if (if_ok) begin
      winner = OWN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the load/store unit.
// One access every two cycles: grant cycle (IDLE) then response cycle (RESP).
// Define MEM_ARB_RR_EN for round-robin arbitration on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [2:0] FETCH_FUNCT3 = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_fault,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [2:0]            dm_funct3,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_fault
);

`ifdef MEM_ARB_RR_EN
  // Seeded as fetch so the first tie goes to the data side
  localparam arb_owner_e LAST_RST = OWN_IF;
`else
  localparam arb_owner_e LAST_RST = OWN_NONE;
`endif

  arb_state_e state_reg, state_next;
  arb_owner_e owner_reg, owner_next;
  arb_owner_e last_grant_reg, last_grant_next;
  logic       store_reg, store_next;
  arb_owner_e winner;
  arb_owner_e grant;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .flush      (flush),
    .last_grant (last_grant_reg),
    .winner     (winner)
  );

  // State, owner and last-grant registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_NONE;
      last_grant_reg <= LAST_RST;
      store_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      store_reg      <= store_next;
    end
  end

  // Next state plus grant-cycle port drive and response-cycle return path
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    store_next      = store_reg;
    if_gnt          = 1'b0;
    if_rvalid       = 1'b0;
    if_rdata        = '0;
    if_fault        = 1'b0;
    dm_gnt          = 1'b0;
    dm_rvalid       = 1'b0;
    dm_rdata        = '0;
    dm_fault        = 1'b0;
    mem_address     = '0;
    mem_data_in     = '0;
    mem_write       = 1'b0;
    mem_read        = 1'b0;
    mem_funct3      = 3'b000;
    // Grants are combinational from req, so mask them while reset is held
    grant           = rst_n ? winner : OWN_NONE;

    case (state_reg)
      ARB_IDLE: begin
        owner_next = OWN_NONE;
        store_next = 1'b0;
        if (grant == OWN_DM) begin
          dm_gnt          = 1'b1;
          mem_address     = dm_addr;
          mem_data_in     = dm_wdata;
          mem_write       = dm_we;
          mem_read        = ~dm_we;
          mem_funct3      = dm_funct3;
          owner_next      = OWN_DM;
          store_next      = dm_we;
          last_grant_next = OWN_DM;
          state_next      = ARB_RESP;
        end else if (grant == OWN_IF) begin
          if_gnt          = 1'b1;
          mem_address     = if_addr;
          mem_read        = 1'b1;
          mem_funct3      = FETCH_FUNCT3;
          owner_next      = OWN_IF;
          last_grant_next = OWN_IF;
          state_next      = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
        owner_next = OWN_NONE;
        store_next = 1'b0;
        // A flushed fetch response is silently dropped
        if (owner_reg == OWN_IF && !flush) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_data_out;
          if_fault  = mem_fault;
        end
        if (owner_reg == OWN_DM) begin
          dm_rvalid = 1'b1;
          dm_rdata  = store_reg ? '0 : mem_data_out;
          dm_fault  = mem_fault;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
// Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [2:0]  dm_funct3;
  logic        if_gnt, if_rvalid, if_fault, dm_gnt, dm_rvalid, dm_fault;
  logic [31:0] if_rdata, dm_rdata, mem_address, mem_data_in;
  logic        mem_write, mem_read;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_data_out = '0;
  logic        mem_fault = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_FUNCT3(3'b010)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_fault(if_fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_fault(dm_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_read(mem_read), .mem_funct3(mem_funct3), .mem_data_out(mem_data_out),
    .mem_fault(mem_fault)
  );

  // ---------------- RAM environment ----------------
  logic [31:0] ram [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return (a[3:0] == 4'hF) || (a == 32'd65533);
  endfunction

  always @(posedge clk) begin
    if (mem_read) mem_data_out <= ram.exists(mem_address) ? ram[mem_address] : init_word(mem_address);
    else          mem_data_out <= '0;
    if (mem_write) ram[mem_address] = mem_data_in;
    mem_fault <= (mem_read || mem_write) ? fault_of(mem_address) : 1'b0;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_busy = 0;     // a response is due this cycle
  int          m_owner = 0;    // 1 fetch, 2 data
  bit          m_store = 0;
  logic [31:0] m_data = '0;
  bit          m_fault = 0;
  bit          m_last_dm = 0;  // last granted requester was data
  logic [31:0] mref [logic [31:0]];

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mref.exists(a) ? mref[a] : init_word(a);
  endfunction

  function automatic int winner_of();
    bit ie = if_req && !flush;
    bit de = dm_req;
`ifdef MEM_ARB_RR_EN
    if (ie && de) return m_last_dm ? 1 : 2;
`endif
    if (de) return 2;
    if (ie) return 1;
    return 0;
  endfunction

  task automatic model_check();
    logic        e_ig = 0, e_dg = 0, e_irv = 0, e_if = 0, e_drv = 0, e_df = 0, e_w = 0, e_r = 0;
    logic [31:0] e_ird = 0, e_drd = 0, e_addr = 0, e_din = 0;
    logic [2:0]  e_f3 = 0;
    int w;
    if (m_busy) begin
      if (m_owner == 1 && !flush) begin e_irv = 1; e_ird = m_data; e_if = m_fault; end
      if (m_owner == 2) begin e_drv = 1; e_drd = m_store ? 32'h0 : m_data; e_df = m_fault; end
    end else begin
      w = winner_of();
      if (w == 2) begin
        e_dg = 1; e_addr = dm_addr; e_din = dm_wdata; e_w = dm_we; e_r = !dm_we; e_f3 = dm_funct3;
      end else if (w == 1) begin
        e_ig = 1; e_addr = if_addr; e_r = 1; e_f3 = 3'b010;
      end
    end
    chk("if_gnt", if_gnt, e_ig);        chk("dm_gnt", dm_gnt, e_dg);
    chk("if_rvalid", if_rvalid, e_irv); chk("if_rdata", if_rdata, e_ird);
    chk("if_fault", if_fault, e_if);    chk("dm_rvalid", dm_rvalid, e_drv);
    chk("dm_rdata", dm_rdata, e_drd);   chk("dm_fault", dm_fault, e_df);
    chk("mem_address", mem_address, e_addr); chk("mem_data_in", mem_data_in, e_din);
    chk("mem_write", mem_write, e_w);   chk("mem_read", mem_read, e_r);
    chk("mem_funct3", mem_funct3, e_f3);
  endtask

  task automatic model_step();
    int w;
    if (m_busy) begin
      m_busy = 0;
    end else begin
      w = winner_of();
      if (w == 1) begin
        m_busy = 1; m_owner = 1; m_store = 0;
        m_data = mread(if_addr); m_fault = fault_of(if_addr); m_last_dm = 0;
        $display("txn %0t: fetch addr=0x%08h", $time, if_addr);
      end else if (w == 2) begin
        m_busy = 1; m_owner = 2; m_store = dm_we;
        m_data = dm_we ? 32'h0 : mread(dm_addr); m_fault = fault_of(dm_addr); m_last_dm = 1;
        if (dm_we) mref[dm_addr] = dm_wdata;
        $display("txn %0t: %s addr=0x%08h f3=%0d wdata=0x%08h", $time, dm_we ? "store" : "load",
                 dm_addr, dm_funct3, dm_wdata);
      end
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd,
                       input logic fl);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_funct3 = f3;
    dm_addr = da; dm_wdata = wd; flush = fl;
  endtask

  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [2:0] f3; logic [31:0] da; logic [31:0] wd;
    logic        fl;
    logic [1:0]  eg;   // {if_gnt, dm_gnt}
    logic [1:0]  erv;  // {if_rvalid, dm_rvalid}
    logic [31:0] erd;  // owner's read data
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd,
                              input logic fl, input logic [1:0] eg, input logic [1:0] erv,
                              input logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.f3 = f3; v.da = da; v.wd = wd;
    v.fl = fl; v.eg = eg; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fetch-only then store/load round trip
    tbl[0]  = mk(1, 32'h8, 0, 0, LW, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    tbl[1]  = mk(0, 32'h0, 0, 0, LW, 0, 0, 0, 2'b00, 2'b10, 32'h3333_3333);
    tbl[2]  = mk(0, 32'h0, 1, 1, SW, 124, 32'h1234_5678, 0, 2'b01, 2'b00, 32'h0);
    tbl[3]  = mk(0, 32'h0, 0, 0, LW, 0, 0, 0, 2'b00, 2'b01, 32'h0);
    tbl[4]  = mk(0, 32'h0, 1, 0, LW, 124, 0, 0, 2'b01, 2'b00, 32'h0);
    tbl[5]  = mk(0, 32'h0, 0, 0, LW, 0, 0, 0, 2'b00, 2'b01, 32'h1234_5678);
    tbl[6]  = mk(1, 32'h8, 0, 0, LW, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    tbl[7]  = mk(0, 32'h0, 0, 0, LW, 0, 0, 0, 2'b00, 2'b10, 32'h3333_3333);
    // both requesting for six cycles
    tbl[8]  = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b01, 2'b00, 32'h0);
    tbl[9]  = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b00, 2'b01, 32'h1234_5678);
`ifdef MEM_ARB_RR_EN
    tbl[10] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b10, 2'b00, 32'h0);
    tbl[11] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b00, 2'b10, 32'h3333_3333);
`else
    tbl[10] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b01, 2'b00, 32'h0);
    tbl[11] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b00, 2'b01, 32'h1234_5678);
`endif
    tbl[12] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b01, 2'b00, 32'h0);
    tbl[13] = mk(1, 32'h8, 1, 0, LW, 124, 0, 0, 2'b00, 2'b01, 32'h1234_5678);

    ram[32'h8]  = 32'h3333_3333;
    mref[32'h8] = 32'h3333_3333;

    // reset with both requests high: everything must stay quiet
    drive(1, 32'h8, 1, 1, SW, 32'h40, 32'hFFFF_FFFF, 0);
    #2;
    chk("rst_if_gnt", if_gnt, 0);       chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_mem_read", mem_read, 0);   chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0); chk("rst_dm_rvalid", dm_rvalid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].f3, tbl[i].da, tbl[i].wd, tbl[i].fl);
      half_check();
      chk($sformatf("vec%0d_gnt", i), {if_gnt, dm_gnt}, tbl[i].eg);
      chk($sformatf("vec%0d_rvalid", i), {if_rvalid, dm_rvalid}, tbl[i].erv);
      chk($sformatf("vec%0d_rdata", i), if_rdata | dm_rdata, tbl[i].erd);
      advance();
    end

    // flushed fetch response, then fetch blocked by flush in IDLE
    drive(1, 32'h8, 0, 0, LW, 0, 0, 0);
    half_check(); chk("flush_pre_gnt", if_gnt, 1); advance();
    drive(0, 32'h0, 0, 0, LW, 0, 0, 1);
    half_check(); chk("flush_rvalid", if_rvalid, 0); chk("flush_rdata", if_rdata, 0); advance();
    drive(1, 32'h8, 0, 0, LW, 0, 0, 1);
    half_check(); chk("flush_idle_gnt", if_gnt, 0); chk("flush_idle_read", mem_read, 0); advance();

    // faulting store
    drive(0, 32'h0, 1, 1, SW, 32'd65533, 32'hDEAD_BEEF, 0);
    half_check(); chk("fault_gnt", dm_gnt, 1); advance();
    drive(0, 32'h0, 0, 0, LW, 0, 0, 0);
    half_check();
    chk("fault_dm_rvalid", dm_rvalid, 1); chk("fault_dm_fault", dm_fault, 1);
    chk("fault_if_fault", if_fault, 0);
    advance();

    // asynchronous reset in the middle of a response
    drive(1, 32'h8, 0, 0, LW, 0, 0, 0);
    half_check(); chk("arst_pre_gnt", if_gnt, 1); advance();
    drive(1, 32'h8, 1, 0, LW, 124, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_if_rvalid", if_rvalid, 0); chk("arst_if_rdata", if_rdata, 0);
    chk("arst_dm_rvalid", dm_rvalid, 0); chk("arst_if_gnt", if_gnt, 0);
    chk("arst_dm_gnt", dm_gnt, 0);       chk("arst_mem_read", mem_read, 0);
    chk("arst_mem_address", mem_address, 0);
    m_busy = 0; m_owner = 0; m_last_dm = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 32'h8, 0, 0, LW, 0, 0, 0);
    half_check(); chk("arst_post_gnt", if_gnt, 1); advance();
    drive(0, 32'h0, 0, 0, LW, 0, 0, 0);
    half_check(); advance();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a_if, a_dm;
      a_if = 32'h100 + 4 * $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: a_dm = 32'd124;
        1: a_dm = 32'h10F;
        default: a_dm = 32'h100 + 4 * $urandom_range(0, 7);
      endcase
      drive($urandom_range(0, 1), a_if, $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 2)), a_dm, $urandom, ($urandom_range(0, 3) == 0));
      half_check();
      advance();
    end

    drive(0, 32'h0, 0, 0, LW, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
